rvsoc_uart: RTL and testbench

Memory-mapped 8N1 serial port of the `rvsoc_wrapper` SoC, attached to the CPU's native peripheral bus beside the SPI-flash controller and on-chip RAM. It serialises bytes written by firmware onto `ser_tx` and deserialises bytes arriving on `ser_rx` into a one-entry receive buffer. It has two registers: a baud divider and a data register. The top level drives `ser_tx` from this block; the system bench decodes it at 100 MHz clock with a bit period of 106 cycles.

---
 rtl/rvsoc_uart_if.sv | 23 ++
 rtl/rvsoc_uart.sv | 238 +++++++++++++++++++++++
 tb/tb_rvsoc_uart.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvsoc_uart_if.sv
// Register-bus bundle between the CPU peripheral port and the UART.
// master = CPU side, slave = UART side.
`timescale 1ns/1ps
interface rvsoc_uart_if;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    modport master (
        output reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
        input  reg_div_do, reg_dat_do, reg_dat_wait
    );

    modport slave (
        input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
        output reg_div_do, reg_dat_do, reg_dat_wait
    );
endinterface

// File: rtl/rvsoc_uart.sv
// rvsoc_uart: memory-mapped 8N1 serial port.
// Byte-lane writable baud divider, stalling transmit register,
// one-entry receive buffer with latest-wins overrun.
`timescale 1ns/1ps
module rvsoc_uart #(
    parameter logic [31:0] DEFAULT_DIV = 32'd106
) (
    input  logic         clk_i,
    input  logic         reset_i,
    rvsoc_uart_if.slave  bus,
    output logic         ser_tx_o,
    input  logic         ser_rx_i
);

    localparam int NUM_LANES = 4;

    // ------------------------------------------------------------------
    // Divider register
    // ------------------------------------------------------------------
    logic [31:0] div_q, div_d;
    logic [31:0] per;

    // Merge enabled byte lanes of the write data into the divider.
    always_comb begin
        div_d = div_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.reg_div_we[i]) div_d[8*i +: 8] = bus.reg_div_di[8*i +: 8];
        end
    end

    // Divider state.
    always_ff @(posedge clk_i) begin
        if (reset_i) div_q <= DEFAULT_DIV;
        else         div_q <= div_d;
    end

    // Periods below two cycles would break the half-period receive sample.
    assign per            = (div_q < 32'd2) ? 32'd2 : div_q;
    assign bus.reg_div_do = div_q;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [9:0]  tx_frame_q, tx_frame_d;   // bit 0 is the bit on the wire
    logic [3:0]  tx_bit_q,   tx_bit_d;     // index of bit on the wire, 0 = start
    logic [31:0] tx_cnt_q,   tx_cnt_d;
    logic [31:0] tx_per_q,   tx_per_d;     // period latched at each bit boundary
    logic        ser_tx_q,   ser_tx_d;

    // Transmit FSM next state. The FSM drops to IDLE one cycle before the stop
    // bit ends so a stalled write is taken exactly on the stop-bit end edge;
    // the line already idles high, so the frame timing is unchanged.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_frame_d = tx_frame_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_per_d   = tx_per_q;
        ser_tx_d   = ser_tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                ser_tx_d = 1'b1;
                if (bus.reg_dat_we) begin
                    tx_frame_d = {1'b1, bus.reg_dat_di[7:0], 1'b0};
                    ser_tx_d   = 1'b0;
                    tx_bit_d   = 4'd0;
                    tx_cnt_d   = 32'd0;
                    tx_per_d   = per;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                tx_cnt_d = tx_cnt_q + 32'd1;
                if (tx_bit_q == 4'd9 && tx_cnt_q == tx_per_q - 32'd2) begin
                    tx_state_d = TX_IDLE;
                    ser_tx_d   = 1'b1;
                end else if (tx_cnt_q == tx_per_q - 32'd1) begin
                    tx_cnt_d   = 32'd0;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    ser_tx_d   = tx_frame_q[1];
                    tx_per_d   = per;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmit state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            tx_frame_q <= 10'h3ff;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= 32'd0;
            tx_per_q   <= 32'd2;
            ser_tx_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_frame_q <= tx_frame_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_per_q   <= tx_per_d;
            ser_tx_q   <= ser_tx_d;
        end
    end

    assign ser_tx_o         = ser_tx_q;
    assign bus.reg_dat_wait = bus.reg_dat_we && (tx_state_q == TX_SHIFT);

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic        rx_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q,   rx_bit_d;
    logic [31:0] rx_cnt_q,   rx_cnt_d;
    logic [31:0] rx_per_q,   rx_per_d;
    logic        rx_store;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_byte_q,  rx_byte_d;

    assign rx_s = rx_sync_q[1];

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], ser_rx_i};
            rx_prev_q <= rx_s;
        end
    end

    // Receive FSM next state. The counter starts at 1 on detection because
    // the edge detector itself costs a cycle; this puts the start-bit sample
    // half a period after the line fell at the synchroniser output.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_cnt_d   = rx_cnt_q;
        rx_per_d   = rx_per_q;
        rx_store   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_cnt_d   = 32'd1;
                    rx_per_d   = per;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + 32'd1;
                if (rx_cnt_q >= (rx_per_q >> 1) - 32'd1) begin
                    rx_cnt_d   = 32'd0;
                    rx_bit_d   = 3'd0;
                    rx_per_d   = per;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q + 32'd1;
                if (rx_cnt_q == rx_per_q - 32'd1) begin
                    rx_cnt_d   = 32'd0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_per_d   = per;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_cnt_q + 32'd1;
                if (rx_cnt_q == rx_per_q - 32'd1) begin
                    rx_store   = rx_s;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receive state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= 8'h00;
            rx_bit_q   <= 3'd0;
            rx_cnt_q   <= 32'd0;
            rx_per_q   <= 32'd2;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_per_q   <= rx_per_d;
        end
    end

    // Receive buffer: a completed byte wins over a read in the same cycle.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_byte_d  = rx_byte_q;
        if (rx_store) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
        end else if (bus.reg_dat_re) begin
            rx_valid_d = 1'b0;
        end
    end

    // Receive buffer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign bus.reg_dat_do = rx_valid_q ? {24'h0, rx_byte_q} : 32'hFFFF_FFFF;

    // Upper transmit data bits carry no meaning.
    logic unused_dat_di;
    assign unused_dat_di = ^bus.reg_dat_di[31:8];

endmodule

// File: tb/tb_rvsoc_uart.sv
// Directed + randomized bench for rvsoc_uart. Expected serial frames and
// register values come from plain bit-period arithmetic on the byte values.
`timescale 1ns/1ps
module tb_rvsoc_uart;
    logic clk = 1'b0;
    logic reset;
    logic ser_tx;
    logic ser_rx;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] m_div;   // model of divider register
    logic [31:0] m_dat;   // model of data register read value

    rvsoc_uart_if bus();

    rvsoc_uart #(.DEFAULT_DIV(32'd106)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .bus      (bus),
        .ser_tx_o (ser_tx),
        .ser_rx_i (ser_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_div(input logic [3:0] we, input logic [31:0] v);
        bus.reg_div_we = we;
        bus.reg_div_di = v;
        tick();
        bus.reg_div_we = 4'b0000;
        for (int i = 0; i < 4; i++) if (we[i]) m_div[8*i +: 8] = v[8*i +: 8];
        @(negedge clk);
        chk("div_readback", bus.reg_div_do, m_div);
        tick();
    endtask

    // Holds a write until accepted; returns the accepting edge and stall count.
    task automatic tx_write(input logic [7:0] b, output int acc, output int stall);
        logic ok = 1'b0;
        stall = 0;
        acc   = -1;
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = {$urandom_range(0, 32'hFFFFFF), b};
        for (int t = 0; t < 20000 && !ok; t++) begin
            @(negedge clk);
            if (!bus.reg_dat_wait) begin
                @(posedge clk); #1;
                acc = cyc;
                ok  = 1'b1;
            end else begin
                stall++;
            end
        end
        bus.reg_dat_we = 1'b0;
        chk("tx_accept", {31'd0, ok}, 32'd1);
    endtask

    // Checks ser_tx at the first, middle and last cycle of every bit of the
    // frame that started at edge acc, and decodes the mid-bit samples.
    task automatic check_frame(input logic [7:0] b, input int acc, input int P, input string tag);
        logic [7:0] dec = 8'h00;
        logic       e;
        for (int off = 0; off < 10 * P; off++) begin
            int k = off / P;
            int r = off % P;
            @(negedge clk);
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[k-1];
            if (r == 0 || r == P / 2 || r == P - 1) chk(tag, {31'd0, ser_tx}, {31'd0, e});
            if (r == P / 2 && k >= 1 && k <= 8) dec[k-1] = ser_tx;
        end
        chk({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
        $display("tx byte 0x%02h '%c'", dec, dec);
    endtask

    // Drives one frame on ser_rx with P cycles per bit. lat is the first
    // cycle (from the start edge) at which the data register reads non-empty.
    task automatic rx_send(input logic [7:0] b, input int P, input logic stop_ok,
                           input logic re_at_store, output int lat);
        logic lvl;
        lat = -1;
        for (int i = 0; i < 10 * P; i++) begin
            int k = i / P;
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = stop_ok;
            else             lvl = b[k-1];
            ser_rx = lvl;
            bus.reg_dat_re = re_at_store && (i == 9 * P + P / 2 + 1);
            @(negedge clk);
            if (lat < 0 && bus.reg_dat_do !== 32'hFFFF_FFFF) lat = i;
            tick();
        end
        ser_rx = 1'b1;
        bus.reg_dat_re = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd();
        bus.reg_dat_re = 1'b1;
        tick();
        bus.reg_dat_re = 1'b0;
        m_dat = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("read_empty", bus.reg_dat_do, m_dat);
        tick();
    endtask

    initial begin
        int acc, acc2, st, st2, lat, P, dv;
        logic [7:0] b;
        logic ok;

        reset = 1'b1;
        ser_rx = 1'b1;
        bus.reg_div_we = 4'b0000;
        bus.reg_div_di = 32'd0;
        bus.reg_dat_we = 1'b0;
        bus.reg_dat_re = 1'b0;
        bus.reg_dat_di = 32'd0;
        m_div = 32'd106;
        m_dat = 32'hFFFF_FFFF;

        // Reset state
        idle(6);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        chk("rst_div",    bus.reg_div_do, m_div);
        chk("rst_dat",    bus.reg_dat_do, m_dat);
        chk("rst_wait",   {31'd0, bus.reg_dat_wait}, 32'd0);
        tick();

        // Single transmit
        tx_write(8'h41, acc, st);
        chk("tx1_stall", st, 0);
        check_frame(8'h41, acc, 106, "tx_A");
        tick();

        // Back-to-back: second write stalls until the first stop bit ends
        tx_write(8'h48, acc, st);
        fork
            check_frame(8'h48, acc, 106, "tx_H");
            tx_write(8'h69, acc2, st2);
        join
        chk("b2b_accept_edge", acc2 - acc, 1060);
        chk("b2b_stall",       st2, 1059);
        check_frame(8'h69, acc2, 106, "tx_i");
        tick();

        // Divider writes
        set_div(4'b0001, 32'hA5A5A514);
        chk("div_20", bus.reg_div_do, 32'd20);
        tx_write(8'hC6, acc, st);
        check_frame(8'hC6, acc, 20, "tx_div20");
        tick();
        set_div(4'b0001, 32'h0);
        tx_write(8'h3A, acc, st);
        check_frame(8'h3A, acc, 2, "tx_div0");
        tick();
        set_div(4'b1111, 32'h12345678);
        set_div(4'b0100, 32'h99AB7766);
        chk("div_lane2", bus.reg_div_do, 32'h12AB5678);
        for (int i = 0; i < 4; i++) set_div(4'($urandom_range(0, 15)), $urandom);

        // Randomized transmit frames, including divider values below two
        for (int i = 0; i < 6; i++) begin
            dv = $urandom_range(0, 16);
            set_div(4'b1111, dv);
            b = 8'($urandom);
            tx_write(b, acc, st);
            check_frame(b, acc, (dv < 2) ? 2 : dv, "tx_rand");
            tick();
        end

        // Reset in the middle of a frame
        set_div(4'b1111, 32'd106);
        tx_write(8'h00, acc, st);
        idle(300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_div = 32'd106;
        @(negedge clk);
        chk("midrst_ser_tx", {31'd0, ser_tx}, 32'd1);
        tick();
        tx_write(8'h5B, acc, st);
        chk("midrst_idle_stall", st, 0);
        check_frame(8'h5B, acc, 106, "tx_after_rst");
        tick();

        // Receive one byte and read it
        rx_send(8'h0D, 106, 1'b1, 1'b0, lat);
        m_dat = 32'h0000_000D;
        chk("rx_latency", lat, 2 + 9 * 106 + 53);
        idle(20);
        @(negedge clk);
        chk("rx_0d", bus.reg_dat_do, m_dat);
        tick();
        rd();

        // Framing error: stop bit low
        rx_send(8'h5A, 106, 1'b0, 1'b0, lat);
        idle(300);
        @(negedge clk);
        chk("rx_framing", bus.reg_dat_do, m_dat);
        tick();

        // Overrun: latest byte wins
        rx_send(8'h31, 106, 1'b1, 1'b0, lat);
        rx_send(8'h32, 106, 1'b1, 1'b0, lat);
        m_dat = 32'h0000_0032;
        idle(20);
        @(negedge clk);
        chk("rx_overrun", bus.reg_dat_do, m_dat);
        tick();

        // Store and read on the same edge: store wins
        rx_send(8'h77, 106, 1'b1, 1'b1, lat);
        m_dat = 32'h0000_0077;
        idle(20);
        @(negedge clk);
        chk("rx_store_vs_read", bus.reg_dat_do, m_dat);
        tick();
        rd();

        // Short low glitch is rejected
        ser_rx = 1'b0;
        idle(20);
        ser_rx = 1'b1;
        idle(300);
        @(negedge clk);
        chk("rx_glitch", bus.reg_dat_do, m_dat);
        tick();

        // Sender clock off by about 3 % in each direction
        rx_send(8'hC3, 109, 1'b1, 1'b0, lat);
        m_dat = 32'h0000_00C3;
        idle(20);
        @(negedge clk);
        chk("rx_slow_sender", bus.reg_dat_do, m_dat);
        tick();
        rd();
        rx_send(8'h96, 103, 1'b1, 1'b0, lat);
        m_dat = 32'h0000_0096;
        idle(20);
        @(negedge clk);
        chk("rx_fast_sender", bus.reg_dat_do, m_dat);
        tick();
        rd();

        // Randomized receive frames at random even periods
        for (int i = 0; i < 8; i++) begin
            logic was_empty;
            P = 2 * $urandom_range(3, 12);
            set_div(4'b1111, P);
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            was_empty = (m_dat == 32'hFFFF_FFFF);
            rx_send(b, P, ok, 1'b0, lat);
            if (ok) m_dat = {24'h0, b};
            if (ok && was_empty) chk("rx_rand_latency", lat, 2 + 9 * P + P / 2);
            idle(3 * P);
            @(negedge clk);
            chk("rx_rand", bus.reg_dat_do, m_dat);
            tick();
            if ($urandom_range(0, 1) == 1) rd();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
